// File: rtl/matraptor_merge_drain.sv
// matraptor_merge_drain: k-way merge of NQ column-sorted queues into one summed, duplicate-free row
// Ports: i_clk/i_rst_n (sync active-low), i_start + i_q_active begin a row, i_q_* queue heads with
// o_q_ready one-hot pop, o_out_* registered ready/valid output row, o_busy, o_row_done pulse.
// Optional macro MATRAPTOR_MERGE_SAT_EN: signed-saturating accumulation (default wraps).
module matraptor_merge_drain #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16,
    parameter int NQ     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [NQ-1:0]        i_q_active,
    input  logic [NQ-1:0]        i_q_valid,
    output logic [NQ-1:0]        o_q_ready,
    input  logic [NQ*DATA_W-1:0] i_q_val,
    input  logic [NQ*IDX_W-1:0]  i_q_col,
    input  logic [NQ-1:0]        i_q_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DATA_W-1:0]    o_out_val,
    output logic [IDX_W-1:0]     o_out_col,
    output logic                 o_out_last,
    output logic                 o_busy,
    output logic                 o_row_done
);
    localparam int SEL_W = $clog2(NQ);
    typedef enum logic [1:0] {IDLE, MERGE, FLUSH, WAIT_OUT} state_t;
    state_t            r_state, w_state_nxt;
    logic [NQ-1:0]     r_pending, w_pending_nxt;
    logic              r_acc_v;
    logic [IDX_W-1:0]  r_acc_col;
    logic [DATA_W-1:0] r_acc_val;
    logic              r_out_valid, r_out_last, r_row_done;
    logic [DATA_W-1:0] r_out_val;
    logic [IDX_W-1:0]  r_out_col;
    logic              w_found, w_all_valid, w_slot_free, w_need_slot, w_pop, w_out_load, w_hs, w_start_ok;
    logic [SEL_W-1:0]  w_sel;
    logic [IDX_W-1:0]  w_sel_col;
    logic [DATA_W-1:0] w_sel_val, w_sum;
    // Minimum column among pending heads; strict compare keeps the lowest index on ties.
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_sel_col = '0;
        for (int i = 0; i < NQ; i++) begin
            if (r_pending[i] && (!w_found || i_q_col[i*IDX_W +: IDX_W] < w_sel_col)) begin
                w_found   = 1'b1;
                w_sel     = SEL_W'(i);
                w_sel_col = i_q_col[i*IDX_W +: IDX_W];
            end
        end
    end
    assign w_sel_val   = i_q_val[w_sel*DATA_W +: DATA_W];
    // Any pending head missing could hide a smaller column, so popping waits for all of them.
    assign w_all_valid = &(i_q_valid | ~r_pending);
    assign w_slot_free = !r_out_valid || i_out_ready;
    assign w_need_slot = r_acc_v && (r_acc_col != w_sel_col);
    assign w_pop       = (r_state == MERGE) && w_found && w_all_valid && (!w_need_slot || w_slot_free);
    assign w_out_load  = (w_pop && w_need_slot) || (r_state == FLUSH && w_slot_free);
    assign w_hs        = r_out_valid && i_out_ready;
    // A start coinciding with row_done is dropped; the sender re-pulses.
    assign w_start_ok  = (r_state == IDLE) && i_start && !r_row_done;
    assign o_q_ready   = w_pop ? ({{(NQ-1){1'b0}}, 1'b1} << w_sel) : '0;
`ifdef MATRAPTOR_MERGE_SAT_EN
    logic [DATA_W:0] w_wide;
    assign w_wide = {r_acc_val[DATA_W-1], r_acc_val} + {w_sel_val[DATA_W-1], w_sel_val};
    assign w_sum  = (w_wide[DATA_W] == w_wide[DATA_W-1]) ? w_wide[DATA_W-1:0] :
                    w_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign w_sum = r_acc_val + w_sel_val;
`endif
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        if (w_pop && i_q_last[w_sel])
            w_pending_nxt[w_sel] = 1'b0;
        case (r_state)
            IDLE:     if (w_start_ok && i_q_active != '0) begin
                          w_state_nxt   = MERGE;
                          w_pending_nxt = i_q_active;
                      end
            MERGE:    w_state_nxt = (w_pending_nxt == '0) ? FLUSH : MERGE;
            FLUSH:    w_state_nxt = w_slot_free ? WAIT_OUT : FLUSH;
            WAIT_OUT: w_state_nxt = w_hs ? IDLE : WAIT_OUT;
            default:  w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending   <= '0;
            r_acc_v     <= 1'b0;
            r_acc_col   <= '0;
            r_acc_val   <= '0;
            r_out_valid <= 1'b0;
            r_out_val   <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
            r_row_done  <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_row_done <= (w_start_ok && i_q_active == '0) || (r_state == WAIT_OUT && w_hs);
            if (w_pop) begin
                r_acc_v   <= 1'b1;
                r_acc_col <= w_sel_col;
                r_acc_val <= (r_acc_v && !w_need_slot) ? w_sum : w_sel_val;
            end else if (r_state == FLUSH && w_slot_free) begin
                r_acc_v <= 1'b0;
            end
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_val   <= r_acc_val;
                r_out_col   <= r_acc_col;
                r_out_last  <= (r_state == FLUSH);
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end
    assign o_out_valid = r_out_valid;
    assign o_out_val   = r_out_val;
    assign o_out_col   = r_out_col;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state != IDLE);
    assign o_row_done  = r_row_done;
endmodule

// File: tb/tb_matraptor_merge_drain.sv
// tb_matraptor_merge_drain: scoreboard bench for the k-way merge drain
module tb_matraptor_merge_drain;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int NQ = 8;
    typedef struct packed {logic [DW-1:0] v; logic [IW-1:0] c; logic l;} out_t;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [NQ-1:0] q_active = '0, q_valid = '0, q_last = '0, q_ready;
    logic [NQ*DW-1:0] q_val = '0;
    logic [NQ*IW-1:0] q_col = '0;
    logic out_valid, out_last, busy, row_done;
    logic [DW-1:0] out_val;
    logic [IW-1:0] out_col;
    int n_chk = 0, n_fail = 0;
    out_t expq[$];
    int popq[$];
    int cnt[NQ], head[NQ];
    logic [DW-1:0] ev[NQ][8];
    logic [IW-1:0] ec[NQ][8];
    logic [NQ-1:0] ven = '0, act = '0;
    int rdone_cnt = 0, bpc = 0, first_pop = -1, last_pop = -1;
    bit seen_ov = 0, have_last = 0, hold = 0;
    logic [IW-1:0] last_col = '0;
    logic [63:0] sv = '0;
    always #5 clk = ~clk;
    matraptor_merge_drain #(.DATA_W(DW), .IDX_W(IW), .NQ(NQ)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_q_active(q_active),
        .i_q_valid(q_valid), .o_q_ready(q_ready), .i_q_val(q_val), .i_q_col(q_col),
        .i_q_last(q_last), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_val(out_val), .o_out_col(out_col), .o_out_last(out_last),
        .o_busy(busy), .o_row_done(row_done)
    );
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask
    function automatic logic [DW-1:0] add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef MATRAPTOR_MERGE_SAT_EN
        if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (s < -64'sh80000000) return 32'h80000000;
`endif
        return s[DW-1:0];
    endfunction
    task automatic clear();
        for (int i = 0; i < NQ; i++) begin cnt[i] = 0; head[i] = 0; end
    endtask
    task automatic load(input int q, input logic [DW-1:0] v, input logic [IW-1:0] c);
        ev[q][cnt[q]] = v;
        ec[q][cnt[q]] = c;
        cnt[q]++;
    endtask
    task automatic drive();
        for (int i = 0; i < NQ; i++) begin
            q_valid[i] = ven[i];
            if (head[i] < cnt[i]) begin
                q_val[i*DW +: DW] = ev[i][head[i]];
                q_col[i*IW +: IW] = ec[i][head[i]];
                q_last[i] = (head[i] == cnt[i] - 1);
            end else begin
                q_val[i*DW +: DW] = $urandom;
                q_col[i*IW +: IW] = '0;
                q_last[i] = 1'b1;
            end
        end
    endtask
    // Reference: visit every entry in (column, queue) order; equal columns fold into one output.
    task automatic build_exp();
        logic [DW-1:0] acc;
        logic [IW-1:0] acol;
        bit have;
        acc = '0; acol = '0; have = 0;
        expq.delete();
        popq.delete();
        for (int col = 0; col < 256; col++)
            for (int i = 0; i < NQ; i++)
                if (act[i])
                    for (int k = 0; k < cnt[i]; k++)
                        if (ec[i][k] == IW'(col)) begin
                            popq.push_back(i);
                            if (have && acol == IW'(col)) acc = add(acc, ev[i][k]);
                            else begin
                                if (have) expq.push_back('{v: acc, c: acol, l: 1'b0});
                                acc = ev[i][k]; acol = IW'(col); have = 1;
                            end
                        end
        if (have) expq.push_back('{v: acc, c: acol, l: 1'b1});
    endtask
    task automatic cycle(input int rmode, input int vmode, input int t);
        logic [NQ-1:0] qr, pend;
        int idx, e;
        @(negedge clk);
        qr = q_ready;
        idx = -1;
        for (int i = 0; i < NQ; i++) begin
            pend[i] = act[i] && head[i] < cnt[i];
            if (qr[i] && idx < 0) idx = i;
        end
        if (pend != '0 && (q_valid & pend) != pend) chk("stall_no_pop", qr, 0);
        if (idx >= 0) begin
            chk("pop_onehot", $onehot(qr), 1);
            e = -1;
            if (popq.size() > 0) e = popq.pop_front();
            chk("pop_order", idx, e);
            if (head[idx] < cnt[idx]) begin
                if (out_valid && !out_ready && have_last) chk("pop_blocked_col", ec[idx][head[idx]], last_col);
                last_col = ec[idx][head[idx]];
                have_last = 1;
            end
            if (first_pop < 0) first_pop = t;
            last_pop = t;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (idx >= 0 && head[idx] < cnt[idx]) head[idx]++;
        if (seen_ov) bpc++;
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : (seen_ov && bpc >= 5);
        for (int i = 0; i < NQ; i++)
            ven[i] = !act[i] ? 1'($urandom_range(0, 1)) : (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (vmode == 2 && t < 2) ven[0] = 1'b0;
        drive();
    endtask
    task automatic run_row(input logic [NQ-1:0] a, input int rmode, input int vmode);
        int t;
        t = 0;
        act = a;
        for (int i = 0; i < NQ; i++) head[i] = 0;
        build_exp();
        have_last = 0; seen_ov = 0; bpc = 0; rdone_cnt = 0; first_pop = -1; last_pop = -1;
        out_ready = (rmode != 2);
        for (int i = 0; i < NQ; i++) ven[i] = act[i] ? 1'b1 : 1'($urandom_range(0, 1));
        if (vmode == 2) ven[0] = 1'b0;
        drive();
        q_active = a;
        start = 1'b1;
        while (rdone_cnt == 0 && t < 3000) begin
            cycle(rmode, vmode, t);
            if (t == 0) chk("busy_running", busy, 1);
            t++;
        end
        chk("row_done_seen", rdone_cnt != 0, 1);
        cycle(0, 0, t);
        cycle(0, 0, t + 1);
        chk("row_done_once", rdone_cnt, 1);
        chk("exp_drained", expq.size(), 0);
        chk("pops_drained", popq.size(), 0);
        chk("idle_after", busy, 0);
    endtask
    task automatic rand_row(output logic [NQ-1:0] a);
        int c, n;
        clear();
        a = NQ'($urandom_range(1, 255));
        for (int q = 0; q < NQ; q++)
            if (a[q]) begin
                c = $urandom_range(0, 3);
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    load(q, ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 100), IW'(c));
                    c += $urandom_range(1, 3);
                end
            end
    endtask
    task automatic scen1();
        clear();
        load(0, 5, 1); load(0, 7, 4);
        load(1, 3, 2); load(1, 2, 4);
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin hold = 0; continue; end
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_val, out_col, out_last}, sv);
            end
            hold = 0;
            if (out_valid) begin
                seen_ov = 1;
                if (out_ready) begin
                    if (expq.size() == 0) chk("out_extra", 1, 0);
                    else begin
                        out_t e;
                        e = expq.pop_front();
                        chk("out_val", out_val, e.v);
                        chk("out_col", out_col, e.c);
                        chk("out_last", out_last, e.l);
                    end
                end else begin
                    hold = 1;
                    sv = {out_val, out_col, out_last};
                end
            end
            if (row_done) rdone_cnt++;
        end
    end
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [NQ-1:0] a;
        clear();
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_q_ready", q_ready, 0);
        chk("rst_out_data", {out_val, out_col, out_last}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        scen1();
        run_row(8'b11, 0, 0);
        clear();
        for (int i = 0; i < NQ; i++) load(i, 1, 10);
        run_row(8'hFF, 0, 0);
        chk("tie_pop_span", last_pop - first_pop, 7);
        scen1();
        run_row(8'b11, 2, 0);
        scen1();
        run_row(8'b11, 0, 2);
        clear();
        load(0, 32'h7FFFFFFF, 0);
        load(1, 32'h7FFFFFFF, 0);
        run_row(8'b11, 0, 0);
        clear();
        act = '0;
        drive();
        q_active = '0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("empty_row_done", row_done, 1);
        chk("empty_no_out", out_valid, 0);
        chk("empty_busy", busy, 0);
        @(negedge clk);
        chk("empty_done_pulse", row_done, 0);
        @(posedge clk);
        #1;
        for (int r = 0; r < 40; r++) begin
            rand_row(a);
            run_row(a, $urandom_range(0, 1), $urandom_range(0, 1));
        end
        scen1();
        act = 8'b11;
        build_exp();
        out_ready = 1'b0;
        ven = 8'b11;
        drive();
        q_active = 8'b11;
        start = 1'b1;
        for (int t = 0; t < 4; t++) cycle(2, 0, t);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_row_done", row_done, 0);
        chk("midrst_q_ready", q_ready, 0);
        chk("midrst_out_data", {out_val, out_col, out_last}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expq.delete();
        popq.delete();
        rand_row(a);
        run_row(a, 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
